// File: rtl/ex_forward_unit.sv
// ---------------------------------------------------------------------------
// ex_forward_unit
//
// Producer side of the EX-stage operand path. The unit keeps shadow copies
// of the MEM-stage and WB-stage destination and result. From these it
// returns in-flight results to the ALU operands. It also detects load-use
// hazards in ID and raises a one-cycle stall.
//
// Ports
//   clk, reset        single clock; synchronous active-high reset
//   id_rs, id_rt      source registers of the instruction in ID
//   id_use_rt         ID instruction reads rt as a source
//   ex_rs, ex_rt      source registers of the instruction in EX
//   rf_rs_data/rt     register-file values for ex_rs / ex_rt
//   ex_valid          EX holds a real instruction (0 = bubble)
//   ex_rd             EX destination register
//   ex_reg_write      EX instruction writes a register
//   ex_mem_read       EX instruction is a load
//   ex_result         ALU result of the EX instruction
//   mem_read_data     data-memory read data for the MEM-stage load
//   operand_a/b       forwarded rs / rt values
//   fwd_sel_a/b       0 = regfile, 1 = WB, 2 = MEM
//   stall             hold PC and IF/ID; bubble into ID/EX
//   stall_count       saturating count of stall cycles since reset
// ---------------------------------------------------------------------------
module ex_forward_unit #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic              id_use_rt,
    input  logic [RA_W-1:0]   ex_rs,
    input  logic [RA_W-1:0]   ex_rt,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    input  logic              ex_valid,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_WB  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    // MEM-stage shadow
    logic              mem_valid;
    logic [RA_W-1:0]   mem_rd;
    logic              mem_load;
    logic [DATA_W-1:0] mem_alu;

    // WB-stage shadow
    logic              wb_valid;
    logic [RA_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;

    // Per-source match terms
    logic a_mem_hit, a_wb_hit;
    logic b_mem_hit, b_wb_hit;
    logic load_use;

    // ------------------------------------------------------------------
    // Shadow pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_rd    <= '0;
            mem_load  <= 1'b0;
            mem_alu   <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            // Writes to $zero never become forwardable.
            mem_valid <= ex_valid & ex_reg_write & (ex_rd != '0);
            mem_rd    <= ex_rd;
            mem_load  <= ex_mem_read;
            mem_alu   <= ex_result;
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            wb_data   <= mem_load ? mem_read_data : mem_alu;
        end
    end

    // ------------------------------------------------------------------
    // Forward match detection
    // ------------------------------------------------------------------
    // Matching is gated by reset. While reset is high the shadow registers
    // still hold pre-reset contents, and nothing may be forwarded from them.
    // A MEM-stage load is excluded, so such a match falls through to WB or
    // to the regfile.
    always_comb begin
        a_mem_hit = 1'b0;
        a_wb_hit  = 1'b0;
        b_mem_hit = 1'b0;
        b_wb_hit  = 1'b0;
        if (!reset) begin
            if (ex_rs != '0) begin
                a_mem_hit = mem_valid & ~mem_load & (mem_rd == ex_rs);
                a_wb_hit  = wb_valid & (wb_rd == ex_rs);
            end
            if (ex_rt != '0) begin
                b_mem_hit = mem_valid & ~mem_load & (mem_rd == ex_rt);
                b_wb_hit  = wb_valid & (wb_rd == ex_rt);
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand A mux: MEM wins over WB (newest writer)
    // ------------------------------------------------------------------
    always_comb begin
        fwd_sel_a = SEL_RF;
        operand_a = rf_rs_data;
        if (a_mem_hit) begin
            fwd_sel_a = SEL_MEM;
            operand_a = mem_alu;
        end else if (a_wb_hit) begin
            fwd_sel_a = SEL_WB;
            operand_a = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Operand B mux
    // ------------------------------------------------------------------
    always_comb begin
        fwd_sel_b = SEL_RF;
        operand_b = rf_rt_data;
        if (b_mem_hit) begin
            fwd_sel_b = SEL_MEM;
            operand_b = mem_alu;
        end else if (b_wb_hit) begin
            fwd_sel_b = SEL_WB;
            operand_b = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard
    // ------------------------------------------------------------------
    // The stall lasts one cycle by construction: the next cycle EX holds
    // the inserted bubble (ex_valid = 0).
    always_comb begin
        load_use = ex_valid & ex_mem_read & (ex_rd != '0) &
                   ((ex_rd == id_rs) | (id_use_rt & (ex_rd == id_rt)));
        stall    = load_use & ~reset;
    end

    // ------------------------------------------------------------------
    // Saturating stall statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
